mem_io: RTL and testbench
=========================

Name: mem_io

Overview:
- Memory and I/O stage directly downstream of the processor core's memory port (Ma/Mrd/Mwd/Mwen).
- Provides word-addressed 16-bit RAM with combinational read; the core consumes Mrd in the same cycle, for both instruction fetch and load.
- Also provides a memory-mapped byte transmit FIFO with valid/ready output, plus a status register and a free-running cycle timer.

Parameters:
- ADDR_BITS, 8, RAM depth is 2**ADDR_BITS words; RAM decode uses Ma[ADDR_BITS-1:0].
- FIFO_DEPTH, 4, transmit FIFO entries; power of two, 2..8.
- IO_BASE, 16'hFF00, base of I/O region; addresses >= IO_BASE are I/O, all others are RAM.

Ports:
- clk  in  1  single clock; all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- Ma  in  16  word address from core.
- Mwd  in  16  write data from core.
- Mwen  in  1  write enable; write takes effect at posedge clk.
- Mrd  out  16  read data; combinational from Ma and current state.
- tx_data  out  8  FIFO head byte.
- tx_valid  out  1  FIFO non-empty.
- tx_ready  in  1  consumer accepts head this cycle.

Behaviour:
- Reset (rst high at posedge):
  - FIFO pointers and count = 0, so tx_valid = 0 and tx_data = 0.
  - overflow flag = 0; timer = 0.
  - RAM contents are NOT reset.
  - Mrd follows decode immediately after reset.
  - Reset wins over any simultaneous write, push or pop.
- RAM region (Ma < IO_BASE):
  - Mrd = ram[Ma[ADDR_BITS-1:0]].
  - Upper address bits alias.
  - Mwen writes Mwd at posedge. A read of the same address in the same cycle returns the old data.
- I/O register map (offset = Ma - IO_BASE):
  - 0 TXDATA
    - Write pushes Mwd[7:0].
    - Read returns {8'h00, head byte}, 0 if empty. Reads never pop.
  - 1 STATUS
    - Read returns {8'h00, count[3:0], 1'b0, overflow, empty, full}.
    - Any write clears overflow.
  - 2 TIMER
    - Read returns the timer.
    - Write loads Mwd; the timer reads Mwd+1 on the following cycle.
  - 3..255 reserved: read 0, writes ignored.
  - Offsets above 255 (only reachable if IO_BASE < 16'hFF00) alias modulo 4 onto offsets 0..3.
- Timer:
  - Increments by 1 every cycle.
  - Wraps from 16'hFFFF to 0.
  - A write has priority over the increment.
- FIFO:
  - pop = tx_valid & tx_ready.
  - push = Mwen & (offset 0 decoded).
  - Push is accepted if count < FIFO_DEPTH, OR count == FIFO_DEPTH and pop occurs in the same cycle.
  - Otherwise the push is dropped and overflow is set (sticky). A clear of overflow in the same cycle is impossible (different addresses).
  - Push and pop together: count is unchanged and the head advances.
  - Pointers wrap modulo FIFO_DEPTH.
  - tx_data must stay stable while tx_valid=1 and tx_ready=0.
  - count is reported saturated to 4 bits.
- Latency:
  - Pushed byte is visible on tx_data/tx_valid the cycle after the push edge.
  - STATUS reflects the push the cycle after the push edge.

Optional Feature:
- MEM_IO_TIMER_EN
  - Defined: timer present as above.
  - Undefined: no timer register; offset 2 reads 16'h0000 and writes are ignored. All other behaviour is identical.

Decomposition:
- Shared package mem_io_pkg:
  - I/O offset constants OFF_TXDATA=0, OFF_STATUS=1, OFF_TIMER=2.
  - STATUS bit indices ST_FULL=0, ST_EMPTY=1, ST_OVF=2, ST_COUNT_LSB=4.
  - Default IO_BASE.
- One natural sub-module: fifo_sync (parameterised depth/width, push/pop/full/empty/count, push-when-full-with-pop accepted).
- RAM, address decode, timer and Mrd mux stay in mem_io.

Test Plan:
- Reset then RAM: write 16'hBEEF to 0x0005 → next cycle Mrd=BEEF at Ma=0x0005. Ma=0x0105 (ADDR_BITS=8) also reads BEEF (alias).
- Push 8'h41, 8'h42 with tx_ready=0 → tx_valid=1, tx_data=41, STATUS=16'h0020. Raise tx_ready for 2 cycles → 41 then 42 delivered, then STATUS=16'h0002.
- Fill 4 bytes with tx_ready=0, push a 5th → STATUS=16'h0045 and the FIFO holds the original 4. Write STATUS → overflow clears (16'h0041).
- Full FIFO with tx_ready=1 and a simultaneous push of 8'h55 → count stays 4; the 55 emerges fifth.
- With MEM_IO_TIMER_EN: write TIMER=16'hFFFE → reads FFFF next cycle, then 0000 (wrap). Without the macro, TIMER reads 0.
- Assert rst mid-stream with 3 bytes queued → next cycle tx_valid=0 and STATUS=16'h0002; RAM data written before reset is still readable.

Source files
------------

// File: rtl/mem_io_pkg.sv
// Shared constants for the mem_io memory/I-O stage: register offsets, STATUS bit
// positions and the default I/O base address.
package mem_io_pkg;

    localparam logic [15:0] IO_BASE_DEFAULT = 16'hFF00;

    localparam logic [7:0] OFF_TXDATA = 8'd0;
    localparam logic [7:0] OFF_STATUS = 8'd1;
    localparam logic [7:0] OFF_TIMER  = 8'd2;

    localparam int unsigned ST_FULL      = 0;
    localparam int unsigned ST_EMPTY     = 1;
    localparam int unsigned ST_OVF       = 2;
    localparam int unsigned ST_COUNT_LSB = 4;

    function automatic logic [3:0] sat_count4(input int unsigned c);
        return (c > 15) ? 4'hF : c[3:0];
    endfunction

endpackage

// File: rtl/mem_io_fifo_sync.sv
// Synchronous FIFO with registered pointers; a push into a full FIFO is accepted
// when a pop happens in the same cycle, otherwise it is dropped and reported.
module mem_io_fifo_sync #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 8,
    localparam int unsigned PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int unsigned CW   = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CW-1:0]    count_o,
    output logic             drop_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push, do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CW'(DEPTH));
    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | do_pop);
    assign drop_o  = push_i & ~do_push;
    assign count_o = count_q;
    // Empty FIFO presents zero so the head never shows stale storage.
    assign rdata_o = empty_o ? '0 : mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && do_push) mem_q[wr_ptr_q] <= wdata_i;
    end

endmodule

// File: rtl/mem_io.sv
// Memory and I/O stage: word RAM with combinational read, byte transmit FIFO,
// STATUS register and a cycle timer present only when MEM_IO_TIMER_EN is defined.
module mem_io
    import mem_io_pkg::*;
#(
    parameter int unsigned ADDR_BITS  = 8,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter logic [15:0] IO_BASE    = IO_BASE_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] Ma,
    input  logic [15:0] Mwd,
    input  logic        Mwen,
    output logic [15:0] Mrd,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready
);

    localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);

    logic [15:0] ram_q [2**ADDR_BITS];
    logic        is_io;
    logic [15:0] io_off;
    logic [7:0]  sel;
    logic        io_wr, push, status_wr;
    logic        fifo_full, fifo_empty, fifo_drop;
    logic [CW-1:0] fifo_count;
    logic        ovf_q;
    logic [15:0] status;
    logic [15:0] timer_rd;

    assign is_io  = (Ma >= IO_BASE);
    assign io_off = Ma - IO_BASE;
    // Offsets past the 256-word register window fold onto the four real registers.
    assign sel    = (io_off[15:8] != 8'h00) ? {6'b0, io_off[1:0]} : io_off[7:0];

    assign io_wr     = Mwen & is_io;
    assign push      = io_wr & (sel == OFF_TXDATA);
    assign status_wr = io_wr & (sel == OFF_STATUS);

    mem_io_fifo_sync #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .wdata_i (Mwd[7:0]),
        .pop_i   (tx_ready),
        .rdata_o (tx_data),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count),
        .drop_o  (fifo_drop)
    );

    assign tx_valid = ~fifo_empty;

    always_ff @(posedge clk) begin
        if (rst)            ovf_q <= 1'b0;
        else if (fifo_drop) ovf_q <= 1'b1;
        else if (status_wr) ovf_q <= 1'b0;
    end

`ifdef MEM_IO_TIMER_EN
    logic        timer_wr;
    logic [15:0] timer_q;

    assign timer_wr = io_wr & (sel == OFF_TIMER);

    // The write cycle itself counts as a tick, so Mwd+1 is visible right after the write.
    always_ff @(posedge clk) begin
        if (rst)           timer_q <= 16'h0000;
        else if (timer_wr) timer_q <= Mwd + 16'd1;
        else               timer_q <= timer_q + 16'd1;
    end

    assign timer_rd = timer_q;
`else
    assign timer_rd = 16'h0000;
`endif

    always_ff @(posedge clk) begin
        if (!rst && Mwen && !is_io) ram_q[Ma[ADDR_BITS-1:0]] <= Mwd;
    end

    always_comb begin
        status                        = 16'h0000;
        status[ST_FULL]               = fifo_full;
        status[ST_EMPTY]              = fifo_empty;
        status[ST_OVF]                = ovf_q;
        status[ST_COUNT_LSB +: 4]     = sat_count4(32'(fifo_count));
    end

    always_comb begin
        Mrd = 16'h0000;
        if (is_io) begin
            case (sel)
                OFF_TXDATA: Mrd = {8'h00, tx_data};
                OFF_STATUS: Mrd = status;
                OFF_TIMER:  Mrd = timer_rd;
                default:    Mrd = 16'h0000;
            endcase
        end else begin
            Mrd = ram_q[Ma[ADDR_BITS-1:0]];
        end
    end

endmodule

// File: tb/tb_mem_io.sv
// Self-checking bench for mem_io: directed scenarios plus a randomized run against a
// queue/array reference model. Honours MEM_IO_TIMER_EN the same way as the design.
module tb_mem_io;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] Ma;
    logic [15:0] Mwd;
    logic        Mwen;
    logic [15:0] Mrd;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;

    int n_cmp = 0;
    int n_err = 0;

    logic [7:0]  q_m [$];
    bit          ovf_m;
    logic [15:0] timer_m;
    logic [15:0] ram_m [256];
    bit          ram_ok [256];

    mem_io dut (
        .clk      (clk),
        .rst      (rst),
        .Ma       (Ma),
        .Mwd      (Mwd),
        .Mwen     (Mwen),
        .Mrd      (Mrd),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready)
    );

    always #5 clk = ~clk;

    // -1 for RAM, otherwise the register offset after folding.
    function automatic int reg_of(input logic [15:0] a);
        int off;
        if (a < 16'hFF00) return -1;
        off = int'(a) - 'hFF00;
        if (off > 255) off = off % 4;
        return off;
    endfunction

    function automatic logic [15:0] exp_mrd();
        int r;
        logic [3:0] cnt;
        r = reg_of(Ma);
        cnt = 4'(q_m.size());
        if (r == -1) return ram_m[Ma[7:0]];
        case (r)
            0: return (q_m.size() > 0) ? {8'h00, q_m[0]} : 16'h0000;
            1: return {8'h00, cnt, 1'b0, ovf_m, q_m.size() == 0, q_m.size() == DEPTH};
`ifdef MEM_IO_TIMER_EN
            2: return timer_m;
`endif
            default: return 16'h0000;
        endcase
    endfunction

    // Advance the reference model by one clock using the current inputs, then clock the DUT.
    task automatic tick();
        int r, n;
        bit pop;
        r   = reg_of(Ma);
        n   = q_m.size();
        pop = (n > 0) && tx_ready;
        if (rst) begin
            q_m.delete();
            ovf_m   = 1'b0;
            timer_m = 16'h0000;
        end else begin
            if (Mwen && r == -1) begin
                ram_m[Ma[7:0]]  = Mwd;
                ram_ok[Ma[7:0]] = 1'b1;
            end
            if (pop) void'(q_m.pop_front());
            if (Mwen && r == 0) begin
                if (n < DEPTH || pop) q_m.push_back(Mwd[7:0]);
                else ovf_m = 1'b1;
            end
            if (Mwen && r == 1) ovf_m = 1'b0;
            if (Mwen && r == 2) timer_m = Mwd + 16'd1;
            else timer_m = timer_m + 16'd1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [15:0] a, input logic [15:0] d);
        Ma = a; Mwd = d; Mwen = 1'b1;
        tick();
        Mwen = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        Ma = 16'hFF01; #1;
        n_cmp++; if (tx_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", tx_valid); end
        n_cmp++; if (tx_data !== 8'h00) begin n_err++; $display("FAIL reset_data: got %h want 00", tx_data); end
        n_cmp++; if (Mrd !== 16'h0002) begin n_err++; $display("FAIL reset_status: got %h want 0002", Mrd); end
        Ma = 16'hFF02; #1;
        n_cmp++; if (Mrd !== exp_mrd()) begin n_err++; $display("FAIL reset_timer: got %h want %h", Mrd, exp_mrd()); end
        Ma = 16'hFF10; #1;
        n_cmp++; if (Mrd !== 16'h0000) begin n_err++; $display("FAIL reserved_read: got %h want 0000", Mrd); end
    endtask

    task automatic test_ram();
        wr(16'h0005, 16'hBEEF);
        Ma = 16'h0005; #1;
        n_cmp++; if (Mrd !== 16'hBEEF) begin n_err++; $display("FAIL ram_read: got %h want BEEF", Mrd); end
        Ma = 16'h0105; #1;
        n_cmp++; if (Mrd !== 16'hBEEF) begin n_err++; $display("FAIL ram_alias: got %h want BEEF", Mrd); end
        Ma = 16'h0205; Mwd = 16'h1234; Mwen = 1'b1; #1;
        n_cmp++; if (Mrd !== 16'hBEEF) begin n_err++; $display("FAIL ram_old_data: got %h want BEEF", Mrd); end
        tick();
        Mwen = 1'b0; Ma = 16'h0005; #1;
        n_cmp++; if (Mrd !== 16'h1234) begin n_err++; $display("FAIL ram_new_data: got %h want 1234", Mrd); end
    endtask

    task automatic test_fifo_basic();
        tx_ready = 1'b0;
        wr(16'hFF00, 16'h0041);
        wr(16'hFF00, 16'h0042);
        Ma = 16'hFF01; #1;
        n_cmp++; if (tx_valid !== 1'b1) begin n_err++; $display("FAIL basic_valid: got %b want 1", tx_valid); end
        n_cmp++; if (tx_data !== 8'h41) begin n_err++; $display("FAIL basic_head: got %h want 41", tx_data); end
        n_cmp++; if (Mrd !== 16'h0020) begin n_err++; $display("FAIL basic_status: got %h want 0020", Mrd); end
        Ma = 16'hFF00; #1;
        n_cmp++; if (Mrd !== 16'h0041) begin n_err++; $display("FAIL basic_txdata_rd: got %h want 0041", Mrd); end
        tick();
        n_cmp++; if (tx_data !== 8'h41) begin n_err++; $display("FAIL basic_no_pop_on_read: got %h want 41", tx_data); end
        tx_ready = 1'b1;
        tick();
        n_cmp++; if (tx_data !== 8'h42) begin n_err++; $display("FAIL basic_second: got %h want 42", tx_data); end
        tick();
        tx_ready = 1'b0;
        Ma = 16'hFF01; #1;
        n_cmp++; if (Mrd !== 16'h0002) begin n_err++; $display("FAIL basic_drained: got %h want 0002", Mrd); end
        n_cmp++; if (tx_valid !== 1'b0) begin n_err++; $display("FAIL basic_valid_low: got %b want 0", tx_valid); end
    endtask

    task automatic test_overflow();
        tx_ready = 1'b0;
        for (int i = 0; i < 4; i++) wr(16'hFF00, 16'h0010 + 16'(i));
        wr(16'hFF00, 16'h0099);
        Ma = 16'hFF01; #1;
        n_cmp++; if (Mrd !== 16'h0045) begin n_err++; $display("FAIL ovf_status: got %h want 0045", Mrd); end
        wr(16'hFF01, 16'h0000);
        #1;
        n_cmp++; if (Mrd !== 16'h0041) begin n_err++; $display("FAIL ovf_clear: got %h want 0041", Mrd); end
        tx_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            n_cmp++;
            if (tx_data !== 8'h10 + 8'(i)) begin
                n_err++; $display("FAIL ovf_drain%0d: got %h want %h", i, tx_data, 8'h10 + 8'(i));
            end
            tick();
        end
        tx_ready = 1'b0; #1;
        n_cmp++; if (tx_valid !== 1'b0) begin n_err++; $display("FAIL ovf_empty: got %b want 0", tx_valid); end
    endtask

    task automatic test_full_push_pop();
        logic [7:0] want [5];
        tx_ready = 1'b0;
        for (int i = 0; i < 4; i++) wr(16'hFF00, 16'h0020 + 16'(i));
        Ma = 16'hFF00; Mwd = 16'h0055; Mwen = 1'b1; tx_ready = 1'b1;
        tick();
        Mwen = 1'b0; tx_ready = 1'b0; Ma = 16'hFF01; #1;
        n_cmp++; if (Mrd !== 16'h0041) begin n_err++; $display("FAIL fpp_status: got %h want 0041", Mrd); end
        want[0] = 8'h21; want[1] = 8'h22; want[2] = 8'h23; want[3] = 8'h55;
        tx_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            n_cmp++;
            if (tx_data !== want[i]) begin
                n_err++; $display("FAIL fpp_order%0d: got %h want %h", i, tx_data, want[i]);
            end
            tick();
        end
        tx_ready = 1'b0;
    endtask

    task automatic test_timer();
        wr(16'hFF02, 16'hFFFE);
        #1;
`ifdef MEM_IO_TIMER_EN
        n_cmp++; if (Mrd !== 16'hFFFF) begin n_err++; $display("FAIL timer_load: got %h want FFFF", Mrd); end
        tick();
        n_cmp++; if (Mrd !== 16'h0000) begin n_err++; $display("FAIL timer_wrap: got %h want 0000", Mrd); end
        tick();
        n_cmp++; if (Mrd !== 16'h0001) begin n_err++; $display("FAIL timer_inc: got %h want 0001", Mrd); end
`else
        n_cmp++; if (Mrd !== 16'h0000) begin n_err++; $display("FAIL timer_absent: got %h want 0000", Mrd); end
        tick();
        n_cmp++; if (Mrd !== 16'h0000) begin n_err++; $display("FAIL timer_absent2: got %h want 0000", Mrd); end
`endif
    endtask

    task automatic test_random();
        logic [15:0] e;
        for (int it = 0; it < 400; it++) begin
            case ($urandom_range(0, 3))
                0:       Ma = 16'hFF00 + 16'($urandom_range(0, 3));
                1:       Ma = 16'hFF00 + 16'($urandom_range(0, 255));
                default: Ma = {8'($urandom_range(0, 254)), 4'h0, 4'($urandom_range(0, 15))};
            endcase
            Mwd      = 16'($urandom);
            Mwen     = ($urandom_range(0, 9) < 4);
            tx_ready = $urandom_range(0, 1) == 1;
            rst      = ($urandom_range(0, 99) < 2);
            #1;
            e = exp_mrd();
            if (reg_of(Ma) != -1 || ram_ok[Ma[7:0]]) begin
                n_cmp++;
                if (Mrd !== e) begin n_err++; $display("FAIL rand_mrd @%h: got %h want %h", Ma, Mrd, e); end
            end
            n_cmp++;
            if (tx_valid !== (q_m.size() > 0)) begin
                n_err++; $display("FAIL rand_valid: got %b want %b", tx_valid, q_m.size() > 0);
            end
            n_cmp++;
            if (tx_data !== ((q_m.size() > 0) ? q_m[0] : 8'h00)) begin
                n_err++; $display("FAIL rand_data: got %h", tx_data);
            end
            tick();
        end
        rst = 1'b0; Mwen = 1'b0; tx_ready = 1'b0;
    endtask

    task automatic test_reset_midstream();
        tx_ready = 1'b0;
        rst = 1'b1; tick(); rst = 1'b0;
        wr(16'h0005, 16'hBEEF);
        for (int i = 0; i < 3; i++) wr(16'hFF00, 16'h0060 + 16'(i));
        rst = 1'b1; Ma = 16'hFF00; Mwd = 16'h0077; Mwen = 1'b1;
        tick();
        rst = 1'b0; Mwen = 1'b0; Ma = 16'hFF01; #1;
        n_cmp++; if (tx_valid !== 1'b0) begin n_err++; $display("FAIL mid_valid: got %b want 0", tx_valid); end
        n_cmp++; if (Mrd !== 16'h0002) begin n_err++; $display("FAIL mid_status: got %h want 0002", Mrd); end
        Ma = 16'h0005; #1;
        n_cmp++; if (Mrd !== 16'hBEEF) begin n_err++; $display("FAIL mid_ram_kept: got %h want BEEF", Mrd); end
        rst = 1'b1; Ma = 16'h0005; Mwd = 16'hDEAD; Mwen = 1'b1;
        tick();
        rst = 1'b0; Mwen = 1'b0; #1;
        n_cmp++; if (Mrd !== 16'hBEEF) begin n_err++; $display("FAIL mid_ram_write_blocked: got %h want BEEF", Mrd); end
    endtask

    initial begin
        rst = 1'b1; Ma = 16'h0000; Mwd = 16'h0000; Mwen = 1'b0; tx_ready = 1'b0;
        ovf_m = 1'b0; timer_m = 16'h0000;
        for (int i = 0; i < 256; i++) begin ram_m[i] = 16'h0000; ram_ok[i] = 1'b0; end
        test_reset();
        test_ram();
        test_fifo_basic();
        test_overflow();
        test_full_push_pop();
        test_timer();
        test_random();
        test_reset_midstream();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: run did not complete, compared %0d", n_cmp);
        $fatal(1, "timeout");
    end

endmodule
